// File: rtl/rob_alloc_ctrl_if.sv
// Dispatch/retire/pointer bundle between rename-dispatch and the ROB allocation controller.
// master = dispatch/ROB side driving requests; slave = the allocation controller.
interface rob_alloc_ctrl_if #(
  parameter int IDX_W = 5
);
  logic [1:0]       disp_req;
  logic [1:0]       num_retired;
  logic             flush;
  logic [1:0]       disp_grant;
  logic [IDX_W-1:0] rob_index_1;
  logic [IDX_W-1:0] rob_index_2;
  logic             stall;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output disp_req, num_retired, flush,
    input  disp_grant, rob_index_1, rob_index_2, stall,
    input  head, tail, count, full, empty, err
  );

  modport slave (
    input  disp_req, num_retired, flush,
    output disp_grant, rob_index_1, rob_index_2, stall,
    output head, tail, count, full, empty, err
  );
endinterface

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation controller: grants up to two in-order dispatch slots per cycle,
// advances head on retirement, and holds dispatch off for a recovery window after a flush.
module rob_alloc_ctrl #(
  parameter int ROB_DEPTH      = 32,
  parameter int IDX_W          = 5,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  rob_alloc_ctrl_if.slave bus
);
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(ROB_DEPTH);
  localparam logic [3:0]     RC_INIT = 4'(RECOVER_CYCLES);

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_rc;
  logic [3:0]       w_rc_next;
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;
  logic             r_err;

  logic [IDX_W:0]   w_free;
  logic [IDX_W:0]   w_nr_ext;
  logic [IDX_W:0]   w_ret;
  logic [IDX_W:0]   w_alloc;
  logic [1:0]       w_grant;
  logic             w_req_err;
  logic             w_ret_err;
  logic [IDX_W-1:0] w_head_next;

  // Grant looks only at registered occupancy, so same-cycle retirement never widens it.
  assign w_free   = DEPTH_C - r_count;
  assign w_nr_ext = {{(IDX_W-1){1'b0}}, bus.num_retired};

  always_comb begin
    w_grant   = 2'b00;
    w_req_err = 1'b0;
    if (r_state == ST_RUN && !bus.flush) begin
      case (bus.disp_req)
        2'b01: begin
          if (w_free != '0) w_grant = 2'b01;
        end
        2'b11: begin
          if (w_free >= (IDX_W+1)'(2))      w_grant = 2'b11;
          else if (w_free == (IDX_W+1)'(1)) w_grant = 2'b01;
        end
        2'b10:   w_req_err = 1'b1;
        default: w_grant = 2'b00;
      endcase
    end
  end

  // Retirement is clamped to occupancy; anything retired during recovery is bogus.
  always_comb begin
    w_ret     = '0;
    w_ret_err = 1'b0;
    if (r_state == ST_RECOVER) begin
      w_ret_err = (bus.num_retired != 2'b00);
    end else if (w_nr_ext > r_count) begin
      w_ret     = r_count;
      w_ret_err = 1'b1;
    end else begin
      w_ret = w_nr_ext;
    end
  end

  assign w_alloc     = (IDX_W+1)'(w_grant[0]) + (IDX_W+1)'(w_grant[1]);
  assign w_head_next = r_head + w_ret[IDX_W-1:0];

  always_comb begin
    w_state_next = r_state;
    w_rc_next    = r_rc;
    if (bus.flush) begin
      w_state_next = ST_RECOVER;
      w_rc_next    = RC_INIT;
    end else if (r_state == ST_RECOVER) begin
      w_rc_next = r_rc - 4'd1;
      if (r_rc == 4'd1) w_state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_rc    <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_rc    <= w_rc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err  <= r_err | w_req_err | w_ret_err;
      r_head <= w_head_next;
      if (bus.flush) begin
        r_tail  <= w_head_next;
        r_count <= '0;
      end else begin
        r_tail  <= r_tail + w_alloc[IDX_W-1:0];
        r_count <= r_count + w_alloc - w_ret;
      end
    end
  end

  assign bus.disp_grant  = w_grant;
  assign bus.stall       = (bus.disp_req & ~w_grant) != 2'b00;
  assign bus.rob_index_1 = r_tail;
  assign bus.rob_index_2 = r_tail + IDX_W'(1);
  assign bus.head        = r_head;
  assign bus.tail        = r_tail;
  assign bus.count       = r_count;
  assign bus.full        = (r_count == DEPTH_C);
  assign bus.empty       = (r_count == '0);
  assign bus.err         = r_err;
endmodule
